// File: rtl/missile_fire_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : missile_fire_scheduler                                        |
// | Description: Fire-button edge detect, cooldown FSM, lowest-free missile    |
// |              slot allocation/occupancy tracking and shared motion tick.    |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module missile_fire_scheduler #(
   parameter int NUM_SLOTS   = 8,
   parameter int COOLDOWN    = 250000,
   parameter int MOVE_PERIOD = 250000,
   parameter int COL_W       = 12
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           fire_btn,
   input  logic [COL_W-1:0]               player_col,
   input  logic                           clear,
   input  logic [NUM_SLOTS-1:0]           slot_done,
   output logic [NUM_SLOTS-1:0]           launch,
   output logic [COL_W-1:0]               launch_col,
   output logic [NUM_SLOTS-1:0]           slot_busy,
   output logic [$clog2(NUM_SLOTS+1)-1:0] active_cnt,
   output logic                           fire_ready,
   output logic                           fire_dropped,
   output logic                           move_tick
);

   localparam int c_CNT_W = $clog2(NUM_SLOTS+1);
   localparam int c_CD_W  = $clog2(COOLDOWN+1);
   localparam int c_MV_W  = $clog2(MOVE_PERIOD);
   localparam logic [c_CD_W-1:0] c_CD_LOAD = c_CD_W'(COOLDOWN-1);
   localparam logic [c_CD_W-1:0] c_CD_ONE  = c_CD_W'(1);
   localparam logic [c_MV_W-1:0] c_MV_LAST = c_MV_W'(MOVE_PERIOD-1);
   localparam logic [c_MV_W-1:0] c_MV_ONE  = c_MV_W'(1);

   typedef enum logic [1:0] {
      S_READY    = 2'd0,
      S_LAUNCH   = 2'd1,
      S_COOLDOWN = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_fire_q;
   logic [c_CD_W-1:0]     r_cd_cnt;
   logic [c_MV_W-1:0]     r_mv_cnt;
   logic                  w_fire_rise;
   logic                  w_accept;
   logic [NUM_SLOTS-1:0]  w_alloc;
   logic [NUM_SLOTS-1:0]  w_busy_nxt;
   logic [c_CNT_W-1:0]    w_cnt_nxt;

   assign w_fire_rise = fire_btn & ~r_fire_q;
   assign w_accept    = w_fire_rise & (r_state == S_READY) & ~(&slot_busy) & ~clear;
   assign fire_ready  = (r_state == S_READY);
   assign move_tick   = (r_mv_cnt == c_MV_LAST);

   // Scan downward so the last assignment wins: lowest free index.
   always_comb begin
      w_alloc = '0;
      for (int i = NUM_SLOTS-1; i >= 0; i--) begin
         if (!slot_busy[i]) begin
            w_alloc    = '0;
            w_alloc[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_busy_nxt = (slot_busy & ~slot_done) | (w_accept ? w_alloc : '0);
      if (clear)
         w_busy_nxt = '0;
   end

   always_comb begin
      w_cnt_nxt = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         w_cnt_nxt = w_cnt_nxt + c_CNT_W'(w_busy_nxt[i]);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_READY:    if (w_accept) w_state_nxt = S_LAUNCH;
         S_LAUNCH:   w_state_nxt = S_COOLDOWN;
         S_COOLDOWN: if (r_cd_cnt == '0) w_state_nxt = S_READY;
         default:    w_state_nxt = S_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_READY;
         r_fire_q     <= 1'b0;
         r_cd_cnt     <= '0;
         launch       <= '0;
         launch_col   <= '0;
         slot_busy    <= '0;
         active_cnt   <= '0;
         fire_dropped <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fire_q     <= fire_btn;
         launch       <= w_accept ? w_alloc : '0;
         slot_busy    <= w_busy_nxt;
         active_cnt   <= w_cnt_nxt;
         fire_dropped <= w_fire_rise & ~w_accept;
         if (w_accept)
            launch_col <= player_col;
         if (r_state == S_LAUNCH)
            r_cd_cnt <= c_CD_LOAD;
         else if (r_state == S_COOLDOWN && r_cd_cnt != '0)
            r_cd_cnt <= r_cd_cnt - c_CD_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || r_mv_cnt == c_MV_LAST)
         r_mv_cnt <= '0;
      else
         r_mv_cnt <= r_mv_cnt + c_MV_ONE;
   end

endmodule
`default_nettype wire

// File: tb/tb_missile_fire_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_missile_fire_scheduler                                     |
// | Description: Self-checking bench with a cycle-level behavioural model.     |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_missile_fire_scheduler;

   localparam int c_CD = 4;
   localparam int c_MP = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fire_btn = 1'b0;
   logic [11:0] player_col = '0;
   logic        clear = 1'b0;
   logic [7:0]  slot_done = '0;
   logic [7:0]  launch;
   logic [11:0] launch_col;
   logic [7:0]  slot_busy;
   logic [3:0]  active_cnt;
   logic        fire_ready;
   logic        fire_dropped;
   logic        move_tick;
   logic [34:0] obs;

   int n_checks = 0;
   int n_errors = 0;

   // model: occupancy mask, cycles left until ready, tick phase
   logic [7:0]  m_busy = '0;
   logic [7:0]  m_launch = '0;
   logic [11:0] m_col = '0;
   logic        m_prev = 1'b0;
   logic        m_drop = 1'b0;
   int          m_lock = 0;
   int          m_phase = 0;

   missile_fire_scheduler #(
      .NUM_SLOTS(8), .COOLDOWN(c_CD), .MOVE_PERIOD(c_MP), .COL_W(12)
   ) dut (
      .clk(clk), .rst(rst), .fire_btn(fire_btn), .player_col(player_col),
      .clear(clear), .slot_done(slot_done), .launch(launch),
      .launch_col(launch_col), .slot_busy(slot_busy), .active_cnt(active_cnt),
      .fire_ready(fire_ready), .fire_dropped(fire_dropped), .move_tick(move_tick)
   );

   always #5 clk = ~clk;

   assign obs = {launch, launch_col, slot_busy, active_cnt, fire_ready, fire_dropped, move_tick};

   function automatic logic [34:0] exp_vec();
      return {m_launch, m_col, m_busy, 4'($countones(m_busy)),
              (m_lock == 0), m_drop, (m_phase == c_MP-1)};
   endfunction

   // Apply one cycle of inputs, advance the model over the edge, sample 1 time unit later.
   task automatic step(input logic r, input logic b, input logic [11:0] col,
                       input logic c, input logic [7:0] d);
      logic       rise, acc;
      logic [7:0] pick;
      rst = r; fire_btn = b; player_col = col; clear = c; slot_done = d;
      @(posedge clk);
      if (r) begin
         m_busy = '0; m_launch = '0; m_col = '0; m_drop = 1'b0; m_lock = 0; m_phase = 0;
      end else begin
         rise = b && !m_prev;
         acc  = rise && (m_lock == 0) && (m_busy != 8'hFF) && !c;
         pick = '0;
         for (int i = 7; i >= 0; i--) if (!m_busy[i]) pick = 8'(1 << i);
         m_launch = acc ? pick : 8'h00;
         if (acc) m_col = col;
         m_drop  = rise && !acc;
         m_busy  = c ? 8'h00 : ((m_busy & ~d) | m_launch);
         m_lock  = acc ? c_CD + 1 : (m_lock > 0 ? m_lock - 1 : 0);
         m_phase = (m_phase + 1) % c_MP;
      end
      m_prev = r ? 1'b0 : b;
      #1;
   endtask

   task automatic test_reset();
      int first = 0;
      int ticks = 0;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      rst = 1'b0;
      n_checks++;
      if (fire_ready !== 1'b1 || slot_busy !== 8'h00 || launch !== 8'h00 ||
          active_cnt !== 4'd0 || fire_dropped !== 1'b0 || launch_col !== 12'd0) begin
         n_errors++;
         $display("FAIL reset_state: got %h want ready=1 others 0", obs);
      end
      for (int i = 1; i <= 24; i++) begin
         if (move_tick === 1'b1) begin
            ticks++;
            if (first == 0) first = i;
         end
         n_checks++;
         if (obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs, exp_vec());
         end
         step(0, 0, 0, 0, 0);
      end
      n_checks++;
      if (first != 8 || ticks != 3) begin
         n_errors++;
         $display("FAIL move_tick: first at %0d count %0d, want first 8 count 3", first, ticks);
      end
   endtask

   task automatic test_single_launch();
      step(0, 1, 12'd100, 0, 0);
      n_checks++;
      if (launch !== 8'h01 || launch_col !== 12'd100 || slot_busy !== 8'h01 ||
          active_cnt !== 4'd1 || fire_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL single_launch: got %h want launch 01 col 100 busy 01 cnt 1", obs);
      end
      for (int j = 1; j <= 5; j++) begin
         step(0, 0, 12'd7, 0, 0);
         n_checks++;
         if (fire_ready !== (j == 5) || obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL single_cooldown T+%0d: got %h want %h", j + 1, obs, exp_vec());
         end
      end
   endtask

   task automatic test_fill_slots();
      step(1, 0, 0, 0, 0);
      for (int s = 0; s < 8; s++) begin
         step(0, 1, 12'($urandom), 0, 0);
         n_checks++;
         if (launch !== 8'(1 << s) || obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL fill_launch %0d: got %h want %h", s, obs, exp_vec());
         end
         for (int j = 0; j < 5; j++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_errors++;
               $display("FAIL fill_idle %0d: got %h want %h", s, obs, exp_vec());
            end
         end
      end
      n_checks++;
      if (slot_busy !== 8'hFF || active_cnt !== 4'd8) begin
         n_errors++;
         $display("FAIL fill_full: got busy %h cnt %0d want ff 8", slot_busy, active_cnt);
      end
      step(0, 1, 12'd5, 0, 0);
      n_checks++;
      if (fire_dropped !== 1'b1 || launch !== 8'h00 || obs !== exp_vec()) begin
         n_errors++;
         $display("FAIL full_drop: got %h want %h", obs, exp_vec());
      end
      step(0, 0, 0, 0, 0);
   endtask

   task automatic test_retire_realloc();
      step(0, 0, 0, 0, 8'h0C);
      n_checks++;
      if (slot_busy !== 8'hF3 || active_cnt !== 4'd6) begin
         n_errors++;
         $display("FAIL retire: got busy %h cnt %0d want f3 6", slot_busy, active_cnt);
      end
      step(0, 1, 12'd321, 0, 0);
      n_checks++;
      if (launch !== 8'h04 || slot_busy !== 8'hF7 || launch_col !== 12'd321) begin
         n_errors++;
         $display("FAIL realloc: got %h want %h", obs, exp_vec());
      end
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 12'd9, 0, 0);
      n_checks++;
      if (fire_dropped !== 1'b1 || launch !== 8'h00 || launch_col !== 12'd321 ||
          obs !== exp_vec()) begin
         n_errors++;
         $display("FAIL cooldown_drop: got %h want %h", obs, exp_vec());
      end
      step(0, 0, 0, 0, 0);
   endtask

   task automatic test_retire_same_cycle();
      step(1, 0, 0, 0, 0);
      step(0, 1, 12'd40, 0, 0);
      for (int j = 0; j < 6; j++) step(0, 0, 0, 0, 0);
      step(0, 1, 12'd41, 0, 8'h01);
      n_checks++;
      if (launch !== 8'h02 || slot_busy !== 8'h02 || active_cnt !== 4'd1 ||
          obs !== exp_vec()) begin
         n_errors++;
         $display("FAIL retire_same_cycle: got %h want launch 02 busy 02", obs);
      end
   endtask

   task automatic test_held_and_clear();
      int launches = 0;
      step(1, 0, 0, 0, 0);
      for (int j = 0; j < 50; j++) begin
         step(0, 1, 12'd77, 0, 0);
         if (launch !== 8'h00) launches++;
         n_checks++;
         if (obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL held_model %0d: got %h want %h", j, obs, exp_vec());
         end
      end
      n_checks++;
      if (launches != 1) begin
         n_errors++;
         $display("FAIL held_once: got %0d launches want 1", launches);
      end
      step(0, 0, 0, 0, 0);
      step(0, 1, 12'd78, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      n_checks++;
      if (fire_ready !== 1'b1 || slot_busy !== 8'h00 || launch !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_in_cooldown: got %h want ready 1 busy 00", obs);
      end
      for (int s = 0; s < 4; s++) begin
         step(0, 1, 12'(s), 0, 0);
         for (int j = 0; j < 5; j++) step(0, 0, 0, 0, 0);
      end
      n_checks++;
      if (slot_busy !== 8'h0F || active_cnt !== 4'd4) begin
         n_errors++;
         $display("FAIL pre_clear: got busy %h want 0f", slot_busy);
      end
      step(0, 1, 12'd55, 1, 0);
      n_checks++;
      if (slot_busy !== 8'h00 || active_cnt !== 4'd0 || fire_dropped !== 1'b1 ||
          launch !== 8'h00 || obs !== exp_vec()) begin
         n_errors++;
         $display("FAIL clear: got %h want %h", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      logic       b = 1'b0;
      logic [7:0] d;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 2) == 0) b = ~b;
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
         step(($urandom_range(0, 199) == 0), b, 12'($urandom),
              ($urandom_range(0, 63) == 0), d);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL random cyc %0d: got %h want %h", n, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_launch();
      test_fill_slots();
      test_retire_realloc();
      test_retire_same_cycle();
      test_held_and_clear();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
